iic_eeprom_ctrl: RTL and testbench
==================================

Name: iic_eeprom_ctrl

Overview:
- I2C master that consumes the one-cycle `write_en` / `read_en` command pulses from the key debounce front end.
- Performs single-byte random write / random read transactions on a 24C02-class EEPROM with an 8-bit word address.
- Sits between key control and the board I2C pins.
- SDA is open-drain: the block only ever pulls SDA low or releases it. SCL is push-pull, with no clock stretching.

Parameters:
- SCL_DIV, 500: `s_clk` cycles per SCL period (50 MHz / 100 kHz). Must be a multiple of 4 and ≥ 8.
- DEV_ADDR, 7'h50: 7-bit EEPROM device address.

Ports:
- s_clk  in  1  system clock.
- s_rst_n  in  1  reset, synchronous, active-low.
- write_en  in  1  one-cycle pulse, starts a write of `wr_data` to `word_addr`.
- read_en  in  1  one-cycle pulse, starts a read from `word_addr`.
- word_addr  in  8  EEPROM word address; sampled on command accept.
- wr_data  in  8  write byte; sampled on command accept.
- scl  out  1  I2C clock.
- sda_oe  out  1  1 = pull SDA low, 0 = release (external pull-up).
- sda_in  in  1  SDA pin level.
- rd_data  out  8  last byte read; holds until the next read completes.
- rd_valid  out  1  one-cycle pulse when `rd_data` is updated.
- busy  out  1  high from command accept until return to IDLE.
- ack_err  out  1  set on any missing ACK; held until the next command is accepted.

Behaviour:
- Reset values: `scl` = 1, `sda_oe` = 0, `rd_data` = 0, `rd_valid` = 0, `busy` = 0, `ack_err` = 0; FSM in IDLE; divider = 0.
- Reset asserted mid-transaction: the same values apply on the next clock edge. No STOP is generated.
- Timing base: the divider counts 0..SCL_DIV/4-1 and produces a `qtick` on its last count. It runs only while not IDLE and is cleared on command accept.
- Each bit slot is 4 quarters:
  - Q0: `scl` = 0; `sda_oe` updated.
  - Q1: `scl` rises.
  - Q2: `scl` = 1; `sda_in` sampled at the end of Q2.
  - Q3: `scl` = 1; `scl` falls at the end of Q3.
- Bytes are sent MSB first.
- START (4 quarters): SDA released with SCL high for 2 quarters, then SDA pulled low, then 1 quarter later SCL low.
- STOP (4 quarters): SDA low with SCL low, SCL high, then SDA released with SCL high for 2 quarters.
- Command accept happens only in IDLE:
  - `write_en` and `read_en` in the same cycle: the write is accepted and the read is dropped.
  - Pulses while `busy` = 1 are ignored.
  - On accept: `busy` = 1 the next cycle, `ack_err` cleared, `word_addr` / `wr_data` latched.
- FSM states: IDLE, START, DEVW, ACK_DW, WADDR, ACK_WA, WDATA, ACK_WD, RSTART, DEVR, ACK_DR, RDATA, MNACK, STOP, DONE.
- Write path: START → DEVW ({DEV_ADDR,0}) → ACK_DW → WADDR → ACK_WA → WDATA → ACK_WD → STOP → DONE.
- Read path: START → DEVW → ACK_DW → WADDR → ACK_WA → RSTART (repeated START) → DEVR ({DEV_ADDR,1}) → ACK_DR → RDATA (SDA released, 8 samples shifted in) → MNACK (SDA released, master NACK) → STOP → DONE.
- ACK states release SDA for the slot. A sampled 1 sets `ack_err` and jumps to STOP. The remaining bytes are skipped.
- Bit counter is 3 bits. A byte ends when the counter wraps from 7 on the Q3 `qtick`.
- DONE (1 cycle):
  - Read path with no error: `rd_data` ← shift register and `rd_valid` = 1.
  - Then IDLE, with `busy` = 0 in the same cycle IDLE is entered.
- Write transaction length: 1+9+9+9+1 = 29 slots → 29·SCL_DIV cycles + 1 DONE cycle, measured from accept to `busy` fall.
- Read transaction length: 1+9+9+1+9+9+1 = 39 slots.

Optional Feature:
- Macro: `IIC_ACK_POLL_EN`.
- Defined: after a successful write's STOP, the FSM enters POLL.
  - POLL: START, {DEV_ADDR,0}, ACK slot, STOP; repeated until ACK = 0.
  - Then DONE. `busy` stays high throughout POLL. A NACK during polling does not set `ack_err`.
  - Poll attempts are capped at 255; on overflow, `ack_err` = 1 and the FSM goes to DONE.
- Not defined: write goes STOP → DONE directly, and the system must wait out the EEPROM tWR externally.

Test Plan:
- Reset mid-read (`s_rst_n` low for 1 cycle at slot 12) → next cycle `scl` = 1, `sda_oe` = 0, `busy` = 0; a new `read_en` then completes normally.
- `write_en`, `word_addr` = 8'h3C, `wr_data` = 8'hA5, EEPROM model ACKs → SDA bytes A0, 3C, A5 observed with START/STOP; `busy` high for exactly 29·SCL_DIV+1 cycles; `ack_err` = 0.
- Then `read_en`, `word_addr` = 8'h3C → bytes A0, 3C, repeated START, A1; model returns A5; master NACK; `rd_valid` pulses once; `rd_data` = 8'hA5.
- Model NACKs the device byte on a write → `ack_err` = 1 after ACK_DW, STOP follows immediately, `busy` drops; `ack_err` stays 1 until the next `write_en` clears it.
- `write_en` and `read_en` in the same cycle, then `read_en` again while busy → only the write transaction appears on the bus; no read occurs; `rd_valid` never pulses.
- With `IIC_ACK_POLL_EN`, model NACKs 3 polls then ACKs → 4 poll frames observed; `busy` falls after the 4th STOP + 1 cycle; `ack_err` = 0.

Source files
------------

// File: rtl/iic_eeprom_ctrl.sv
// ---------------------------------------------------------------------------
// iic_eeprom_ctrl
//
// I2C master for single-byte random write / random read transactions on a
// 24C02-class EEPROM with an 8-bit word address. Commands arrive as
// one-cycle pulses from the key debounce front end. SDA is open-drain
// (the block only pulls low or releases); SCL is push-pull, no stretching.
//
// Parameters:
//   SCL_DIV   s_clk cycles per SCL period, multiple of 4 and >= 8
//   DEV_ADDR  7-bit EEPROM device address
//
// Ports:
//   s_clk      system clock
//   s_rst_n    synchronous active-low reset
//   write_en   pulse: write wr_data to word_addr
//   read_en    pulse: read from word_addr (write wins if both pulse)
//   word_addr  word address, latched on command accept
//   wr_data    write byte, latched on command accept
//   scl        I2C clock
//   sda_oe     1 = pull SDA low, 0 = release
//   sda_in     SDA pin level
//   rd_data    last byte read, held until the next read completes
//   rd_valid   one-cycle pulse when rd_data updates
//   busy       high from command accept until back in IDLE
//   ack_err    missing ACK seen; cleared on the next accepted command
//
// Optional feature (macro IIC_ACK_POLL_EN): after a successful write the
// master ACK-polls the device (START, device-write byte, ACK, STOP) until it
// answers, capped at 255 NACKed attempts, before finishing.
// ---------------------------------------------------------------------------
module iic_eeprom_ctrl #(
    parameter int unsigned SCL_DIV  = 500,
    parameter logic [6:0]  DEV_ADDR = 7'h50
) (
    input  logic       s_clk,
    input  logic       s_rst_n,
    input  logic       write_en,
    input  logic       read_en,
    input  logic [7:0] word_addr,
    input  logic [7:0] wr_data,
    output logic       scl,
    output logic       sda_oe,
    input  logic       sda_in,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic       ack_err
);

    localparam int unsigned QDIV = SCL_DIV / 4;
    localparam int unsigned QW   = (QDIV > 1) ? $clog2(QDIV) : 1;

    typedef enum logic [4:0] {
        IDLE, START, DEVW, ACK_DW, WADDR, ACK_WA, WDATA, ACK_WD,
        RSTART, DEVR, ACK_DR, RDATA, MNACK, STOP, DONE
`ifdef IIC_ACK_POLL_EN
        , P_START, P_DEV, P_ACK, P_STOP
`endif
    } state_t;

    state_t        state, state_next;
    logic [QW-1:0] qcnt;
    logic [1:0]    qtr;
    logic [2:0]    bit_cnt;
    logic          is_read;
    logic [7:0]    addr_q;
    logic [7:0]    data_q;
    logic [7:0]    shift;
    logic          samp;

    logic          qtick;
    logic          slot_end;
    logic          sample;
    logic          accept;
    logic          set_err;
    logic          byte_state;
    logic [7:0]    tx_byte;
    logic          tx_bit;
    logic          scl_d;
    logic          sda_oe_d;

`ifdef IIC_ACK_POLL_EN
    logic [7:0]    poll_cnt;
    logic          poll_nack;
`endif

    assign qtick    = (state != IDLE) && (qcnt == QW'(QDIV - 1));
    assign sample   = qtick && (qtr == 2'd2);
    assign slot_end = qtick && (qtr == 2'd3);
    assign accept   = (state == IDLE) && (write_en || read_en);
    assign busy     = (state != IDLE);
    assign tx_bit   = tx_byte[3'd7 - bit_cnt];

    // State register.
    always_ff @(posedge s_clk) begin
        if (!s_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and bus-level decode. The bus levels are registered in the
    // datapath, so the whole waveform trails the state by one clock, which
    // keeps scl/sda_oe glitch-free.
    always_comb begin
        state_next = state;
        set_err    = 1'b0;
        byte_state = 1'b0;
        tx_byte    = 8'h00;
        scl_d      = 1'b1;
        sda_oe_d   = 1'b0;

        case (state)
            IDLE: begin
                if (accept) state_next = START;
            end
            START: begin
                scl_d    = (qtr != 2'd3);
                sda_oe_d = qtr[1];
                if (slot_end) state_next = DEVW;
            end
            DEVW: begin
                byte_state = 1'b1;
                tx_byte    = {DEV_ADDR, 1'b0};
                if (slot_end && bit_cnt == 3'd7) state_next = ACK_DW;
            end
            ACK_DW: begin
                if (slot_end) begin
                    set_err    = samp;
                    state_next = samp ? STOP : WADDR;
                end
            end
            WADDR: begin
                byte_state = 1'b1;
                tx_byte    = addr_q;
                if (slot_end && bit_cnt == 3'd7) state_next = ACK_WA;
            end
            ACK_WA: begin
                if (slot_end) begin
                    set_err = samp;
                    if (samp)         state_next = STOP;
                    else if (is_read) state_next = RSTART;
                    else              state_next = WDATA;
                end
            end
            WDATA: begin
                byte_state = 1'b1;
                tx_byte    = data_q;
                if (slot_end && bit_cnt == 3'd7) state_next = ACK_WD;
            end
            ACK_WD: begin
                if (slot_end) begin
                    set_err    = samp;
                    state_next = STOP;
                end
            end
            // SCL is low on entry after the ACK slot, so the repeated START
            // releases SDA with SCL low first; otherwise the slave's ACK
            // release with SCL high would look like a STOP.
            RSTART: begin
                scl_d    = (qtr == 2'd1) || (qtr == 2'd2);
                sda_oe_d = qtr[1];
                if (slot_end) state_next = DEVR;
            end
            DEVR: begin
                byte_state = 1'b1;
                tx_byte    = {DEV_ADDR, 1'b1};
                if (slot_end && bit_cnt == 3'd7) state_next = ACK_DR;
            end
            ACK_DR: begin
                if (slot_end) begin
                    set_err    = samp;
                    state_next = samp ? STOP : RDATA;
                end
            end
            RDATA: begin
                byte_state = 1'b1;
                if (slot_end && bit_cnt == 3'd7) state_next = MNACK;
            end
            MNACK: begin
                if (slot_end) state_next = STOP;
            end
            STOP: begin
                scl_d    = (qtr != 2'd0);
                sda_oe_d = !qtr[1];
                if (slot_end) begin
`ifdef IIC_ACK_POLL_EN
                    state_next = (!is_read && !ack_err) ? P_START : DONE;
`else
                    state_next = DONE;
`endif
                end
            end
            DONE: begin
                state_next = IDLE;
            end
`ifdef IIC_ACK_POLL_EN
            P_START: begin
                scl_d    = (qtr != 2'd3);
                sda_oe_d = qtr[1];
                if (slot_end) state_next = P_DEV;
            end
            P_DEV: begin
                byte_state = 1'b1;
                tx_byte    = {DEV_ADDR, 1'b0};
                if (slot_end && bit_cnt == 3'd7) state_next = P_ACK;
            end
            P_ACK: begin
                if (slot_end) state_next = P_STOP;
            end
            P_STOP: begin
                scl_d    = (qtr != 2'd0);
                sda_oe_d = !qtr[1];
                if (slot_end) begin
                    if (!poll_nack) begin
                        state_next = DONE;
                    end else if (poll_cnt == 8'hFF) begin
                        set_err    = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next = P_START;
                    end
                end
            end
`endif
            default: state_next = IDLE;
        endcase

        // Bit slots: SCL low in Q0, high for Q1..Q3. Only transmit bytes
        // drive SDA; ACK, read and master-NACK slots leave it released.
        if (byte_state || state == ACK_DW || state == ACK_WA || state == ACK_WD ||
            state == ACK_DR || state == MNACK
`ifdef IIC_ACK_POLL_EN
            || state == P_ACK
`endif
            ) begin
            scl_d    = (qtr != 2'd0);
            sda_oe_d = (byte_state && state != RDATA) ? !tx_bit : 1'b0;
        end
    end

    // Quarter timing, bit counting, sampling and result registers.
    always_ff @(posedge s_clk) begin
        if (!s_rst_n) begin
            qcnt     <= '0;
            qtr      <= 2'd0;
            bit_cnt  <= 3'd0;
            is_read  <= 1'b0;
            addr_q   <= 8'h00;
            data_q   <= 8'h00;
            shift    <= 8'h00;
            samp     <= 1'b0;
            scl      <= 1'b1;
            sda_oe   <= 1'b0;
            rd_data  <= 8'h00;
            rd_valid <= 1'b0;
            ack_err  <= 1'b0;
`ifdef IIC_ACK_POLL_EN
            poll_cnt  <= 8'h00;
            poll_nack <= 1'b0;
`endif
        end else begin
            scl      <= scl_d;
            sda_oe   <= sda_oe_d;
            rd_valid <= 1'b0;

            if (accept) begin
                qcnt    <= '0;
                qtr     <= 2'd0;
                bit_cnt <= 3'd0;
                is_read <= !write_en;
                addr_q  <= word_addr;
                data_q  <= wr_data;
                ack_err <= 1'b0;
`ifdef IIC_ACK_POLL_EN
                poll_cnt  <= 8'h00;
                poll_nack <= 1'b0;
`endif
            end else if (state == IDLE) begin
                qcnt <= '0;
            end else begin
                qcnt <= qtick ? '0 : qcnt + QW'(1);
                if (qtick) qtr <= qtr + 2'd1;
                if (slot_end && byte_state) bit_cnt <= bit_cnt + 3'd1;
                if (sample) begin
                    samp <= sda_in;
                    if (state == RDATA) shift <= {shift[6:0], sda_in};
                end
                if (set_err) ack_err <= 1'b1;
                if (state == DONE && is_read && !ack_err) begin
                    rd_data  <= shift;
                    rd_valid <= 1'b1;
                end
`ifdef IIC_ACK_POLL_EN
                if (slot_end && state == P_START) poll_nack <= 1'b0;
                if (slot_end && state == P_ACK && samp) begin
                    poll_nack <= 1'b1;
                    poll_cnt  <= poll_cnt + 8'd1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_iic_eeprom_ctrl.sv
// ---------------------------------------------------------------------------
// tb_iic_eeprom_ctrl
//
// Self-checking bench for iic_eeprom_ctrl with a behavioural 24C02-style
// EEPROM on the open-drain SDA line. Expected bus events (START, STOP, and
// each byte with its ACK bit) are queued when a command is issued and
// compared as the bus monitor decodes them. Also covers transaction length,
// ack_err behaviour, command arbitration and reset mid-transaction.
// Define IIC_ACK_POLL_EN for both bench and RTL to exercise ACK polling.
// ---------------------------------------------------------------------------
module tb_iic_eeprom_ctrl;

    localparam int SCL_DIV    = 16;
    localparam int POLL_NACKS = 3;
    localparam int EV_START   = 1000;
    localparam int EV_STOP    = 2000;
    localparam int LIMIT      = 100 * SCL_DIV;
`ifdef IIC_ACK_POLL_EN
    localparam int WR_LEN     = (29 + 11 * (POLL_NACKS + 1)) * SCL_DIV + 1;
`else
    localparam int WR_LEN     = 29 * SCL_DIV + 1;
`endif
    localparam int RD_LEN     = 39 * SCL_DIV + 1;
    localparam int NACK_LEN   = 11 * SCL_DIV + 1;

    logic       s_clk = 1'b0;
    logic       s_rst_n = 1'b0;
    logic       write_en = 1'b0;
    logic       read_en = 1'b0;
    logic [7:0] word_addr = 8'h00;
    logic [7:0] wr_data = 8'h00;
    logic       scl;
    logic       sda_oe;
    logic       sda_in;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       busy;
    logic       ack_err;

    logic       slave_pull = 1'b0;
    assign sda_in = !(sda_oe || slave_pull);

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int rv_count = 0;

    // EEPROM model state
    logic [7:0] mem [256];
    logic       mon_en = 1'b1;
    int         force_nack = 0;
    int         busy_nacks = 0;
    int         poll_cfg = 0;
    logic       wrote = 1'b0;

    iic_eeprom_ctrl #(.SCL_DIV(SCL_DIV), .DEV_ADDR(7'h50)) dut (
        .s_clk    (s_clk),
        .s_rst_n  (s_rst_n),
        .write_en (write_en),
        .read_en  (read_en),
        .word_addr(word_addr),
        .wr_data  (wr_data),
        .scl      (scl),
        .sda_oe   (sda_oe),
        .sda_in   (sda_in),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy),
        .ack_err  (ack_err)
    );

    always #5 s_clk = ~s_clk;

    task automatic checkOutput(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic logEvent(input int ev);
        if (exp_q.size() == 0) checkOutput("bus_extra", ev, -1);
        else                   checkOutput("bus_event", ev, exp_q.pop_front());
    endtask

    // Counts rd_valid pulses.
    initial begin
        forever begin
            @(negedge s_clk);
            if (rd_valid) rv_count++;
        end
    end

    // Bus monitor and EEPROM slave, sampled on the falling system clock.
    initial begin
        logic       scl_p, sda_p, sda_now, ack_now;
        logic       reading;
        logic [7:0] sh, mem_addr;
        int         bitn, byte_idx;
        scl_p = 1'b1; sda_p = 1'b1; reading = 1'b0; sh = 8'h00; mem_addr = 8'h00;
        bitn = 0; byte_idx = 0;
        forever begin
            @(negedge s_clk);
            sda_now = sda_in;
            if (!mon_en) begin
                bitn = 0; byte_idx = 0; reading = 1'b0; slave_pull = 1'b0;
            end else if (scl_p && scl && sda_p && !sda_now) begin
                logEvent(EV_START);
                bitn = 0; byte_idx = 0; reading = 1'b0;
            end else if (scl_p && scl && !sda_p && sda_now) begin
                logEvent(EV_STOP);
                if (wrote) begin busy_nacks = poll_cfg; wrote = 1'b0; end
            end else if (!scl_p && scl) begin
                if (bitn < 8) begin
                    sh = {sh[6:0], sda_now};
                    bitn++;
                end else begin
                    logEvent((sda_now ? 256 : 0) + int'(sh));
                    if (byte_idx == 0) reading = sh[0];
                    else if (byte_idx == 1 && !reading) mem_addr = sh;
                    else if (byte_idx == 2 && !reading) begin mem[mem_addr] = sh; wrote = 1'b1; end
                    bitn = 0;
                    byte_idx++;
                end
            end else if (scl_p && !scl) begin
                slave_pull = 1'b0;
                if (bitn == 8) begin
                    if (byte_idx == 0) begin
                        ack_now = (sh[7:1] == 7'h50) && force_nack == 0 && busy_nacks == 0;
                        if (force_nack > 0) force_nack--;
                        else if (busy_nacks > 0) busy_nacks--;
                        slave_pull = ack_now;
                    end else if (!reading) begin
                        slave_pull = 1'b1;
                    end
                end else if (reading && byte_idx == 1) begin
                    slave_pull = !mem[mem_addr][3'(7 - bitn)];
                end
            end
            scl_p = scl;
            sda_p = sda_now;
        end
    end

    task automatic pushWrite(input logic [7:0] a, input logic [7:0] d);
        exp_q.push_back(EV_START); exp_q.push_back('hA0);
        exp_q.push_back(int'(a));  exp_q.push_back(int'(d));
        exp_q.push_back(EV_STOP);
`ifdef IIC_ACK_POLL_EN
        for (int i = 0; i < POLL_NACKS; i++) begin
            exp_q.push_back(EV_START); exp_q.push_back('h1A0); exp_q.push_back(EV_STOP);
        end
        exp_q.push_back(EV_START); exp_q.push_back('hA0); exp_q.push_back(EV_STOP);
`endif
    endtask

    task automatic pushRead(input logic [7:0] a, input logic [7:0] d);
        exp_q.push_back(EV_START); exp_q.push_back('hA0);
        exp_q.push_back(int'(a));  exp_q.push_back(EV_START);
        exp_q.push_back('hA1);     exp_q.push_back(256 + int'(d));
        exp_q.push_back(EV_STOP);
    endtask

    // Pulses the command inputs for one cycle; returns one cycle after accept.
    task automatic applyStimulus(input logic we, input logic re,
                                 input logic [7:0] a, input logic [7:0] d);
        @(negedge s_clk);
        write_en = we; read_en = re; word_addr = a; wr_data = d;
        @(negedge s_clk);
        write_en = 1'b0; read_en = 1'b0;
    endtask

    task automatic waitIdle(output int cycles);
        cycles = 0;
        while (busy && cycles < LIMIT) begin
            cycles++;
            @(negedge s_clk);
        end
        if (busy) checkOutput("busy_timeout", int'(busy), 0);
    endtask

    initial begin
        int len, rv0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
`ifdef IIC_ACK_POLL_EN
        poll_cfg = POLL_NACKS;
`endif
        // Reset values
        repeat (3) @(negedge s_clk);
        checkOutput("rst_scl", int'(scl), 1);
        checkOutput("rst_sda_oe", int'(sda_oe), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_rd_valid", int'(rd_valid), 0);
        checkOutput("rst_ack_err", int'(ack_err), 0);
        checkOutput("rst_rd_data", int'(rd_data), 0);
        s_rst_n = 1'b1;
        repeat (2) @(negedge s_clk);

        // Write 0xA5 to 0x3C
        $display("[TB] write 3C <- A5");
        pushWrite(8'h3C, 8'hA5);
        applyStimulus(1'b1, 1'b0, 8'h3C, 8'hA5);
        checkOutput("busy_accept", int'(busy), 1);
        waitIdle(len);
        checkOutput("write_len", len, WR_LEN);
        checkOutput("write_ack_err", int'(ack_err), 0);
        checkOutput("write_q_empty", exp_q.size(), 0);

        // Read back 0x3C
        $display("[TB] read 3C");
        rv0 = rv_count;
        pushRead(8'h3C, 8'hA5);
        applyStimulus(1'b0, 1'b1, 8'h3C, 8'h00);
        waitIdle(len);
        repeat (2) @(negedge s_clk);
        checkOutput("read_len", len, RD_LEN);
        checkOutput("read_rv_pulses", rv_count - rv0, 1);
        checkOutput("read_data", int'(rd_data), 'hA5);
        checkOutput("read_ack_err", int'(ack_err), 0);

        // Device byte NACKed on a write
        $display("[TB] write with device NACK");
        force_nack = 1;
        exp_q.push_back(EV_START); exp_q.push_back('h1A0); exp_q.push_back(EV_STOP);
        applyStimulus(1'b1, 1'b0, 8'h10, 8'h55);
        waitIdle(len);
        checkOutput("nack_len", len, NACK_LEN);
        checkOutput("nack_ack_err", int'(ack_err), 1);
        repeat (5) @(negedge s_clk);
        checkOutput("nack_ack_err_hold", int'(ack_err), 1);
        checkOutput("nack_rd_data_hold", int'(rd_data), 'hA5);

        // Next write clears ack_err
        pushWrite(8'h11, 8'h66);
        applyStimulus(1'b1, 1'b0, 8'h11, 8'h66);
        checkOutput("clear_ack_err", int'(ack_err), 0);
        waitIdle(len);
        checkOutput("clear_len", len, WR_LEN);

        // Simultaneous write+read, then read while busy: only the write runs
        $display("[TB] arbitration");
        rv0 = rv_count;
        pushWrite(8'h20, 8'hC3);
        applyStimulus(1'b1, 1'b1, 8'h20, 8'hC3);
        repeat (20) @(negedge s_clk);
        read_en = 1'b1;
        @(negedge s_clk);
        read_en = 1'b0;
        waitIdle(len);
        checkOutput("arb_len", len, WR_LEN - 21);
        repeat (SCL_DIV * 4) @(negedge s_clk);
        checkOutput("arb_no_read", int'(busy), 0);
        checkOutput("arb_rv_pulses", rv_count - rv0, 0);
        checkOutput("arb_q_empty", exp_q.size(), 0);

        // Reset during a read, at slot 12
        $display("[TB] reset mid-read");
        mon_en = 1'b0;
        applyStimulus(1'b0, 1'b1, 8'h3C, 8'h00);
        repeat (12 * SCL_DIV - 1) @(negedge s_clk);
        s_rst_n = 1'b0;
        @(negedge s_clk);
        s_rst_n = 1'b1;
        checkOutput("mid_rst_scl", int'(scl), 1);
        checkOutput("mid_rst_sda_oe", int'(sda_oe), 0);
        checkOutput("mid_rst_busy", int'(busy), 0);
        repeat (3) @(negedge s_clk);
        mon_en = 1'b1;
        @(negedge s_clk);

        rv0 = rv_count;
        pushRead(8'h20, 8'hC3);
        applyStimulus(1'b0, 1'b1, 8'h20, 8'h00);
        waitIdle(len);
        repeat (2) @(negedge s_clk);
        checkOutput("post_rst_len", len, RD_LEN);
        checkOutput("post_rst_rv", rv_count - rv0, 1);
        checkOutput("post_rst_data", int'(rd_data), 'hC3);
        checkOutput("final_q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
